// File: rtl/adc_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_scanner_if
// Brief    : Bundles the ADC sample stream, result strobe and serial TX user
//            port of the round-robin ADC scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_scanner_if;
  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic [9:0] result;
  logic [3:0] result_channel;
  logic       new_result;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  // The scanner is the master: it requests channels and produces results.
  modport master (
    output channel, result, result_channel, new_result, tx_data, new_tx_data,
    input  new_sample, sample, sample_channel, tx_busy
  );

  modport slave (
    input  channel, result, result_channel, new_result, tx_data, new_tx_data,
    output new_sample, sample, sample_channel, tx_busy
  );
endinterface
`default_nettype wire

// File: rtl/adc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : adc_scanner
// Brief    : Round-robin ADC scan controller; averages 2^AVG_SHIFT samples per
//            enabled channel and emits a result strobe plus a two-byte frame.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scanner #(
  parameter logic [15:0] CHAN_MASK = 16'h03F3,
  parameter int unsigned AVG_SHIFT = 4,
  parameter int unsigned SETTLE    = 1
) (
  input wire            clk,
  input wire            rst,
  adc_scanner_if.master bus
);

  function automatic logic [3:0] lowest_bit(input logic [15:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  localparam logic [15:0] EFF_MASK = (CHAN_MASK == 16'h0000) ? 16'h0001 : CHAN_MASK;
  localparam int ACC_W = 10 + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic [3:0]       FIRST_CH    = lowest_bit(EFF_MASK);
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_SETTLE  = 3'd0,
    S_ACCUM   = 3'd1,
    S_SEND_LO = 3'd2,
    S_WAIT_LO = 3'd3,
    S_SEND_HI = 3'd4,
    S_WAIT_HI = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t           state_q,          state_d;
  logic [3:0]       channel_q,        channel_d;
  logic [3:0]       settle_q,         settle_d;
  logic [ACC_W-1:0] acc_q,            acc_d;
  logic [CNT_W-1:0] cnt_q,            cnt_d;
  logic [9:0]       result_q,         result_d;
  logic [3:0]       result_channel_q, result_channel_d;
  logic             new_result_q,     new_result_d;
  logic [7:0]       tx_data_q,        tx_data_d;
  logic             new_tx_data_q,    new_tx_data_d;

  logic             sample_match;
  logic [ACC_W-1:0] acc_sum;
  logic [3:0]       next_channel;

  assign sample_match = bus.new_sample && (bus.sample_channel == channel_q);
  assign acc_sum      = acc_q + ACC_W'(bus.sample);

  // Descending scan leaves the lowest enabled channel above the current one.
  always_comb begin
    next_channel = FIRST_CH;
    for (int i = 15; i >= 0; i--) begin
      if (EFF_MASK[i] && (4'(i) > channel_q)) next_channel = 4'(i);
    end
  end

  always_comb begin
    state_d          = state_q;
    channel_d        = channel_q;
    settle_d         = settle_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    result_d         = result_q;
    result_channel_d = result_channel_q;
    new_result_d     = 1'b0;
    tx_data_d        = tx_data_q;
    new_tx_data_d    = 1'b0;

    case (state_q)
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_ACCUM;
        end else if (sample_match) begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_ACCUM: begin
        if (sample_match) begin
          if (cnt_q == CNT_LAST) begin
            result_d         = 10'(acc_sum >> AVG_SHIFT);
            result_channel_d = channel_q;
            new_result_d     = 1'b1;
            acc_d            = '0;
            cnt_d            = '0;
            state_d          = S_SEND_LO;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SEND_LO: begin
        if (!bus.tx_busy) begin
          tx_data_d     = result_q[7:0];
          new_tx_data_d = 1'b1;
          state_d       = S_WAIT_LO;
        end
      end
      // The TX busy flag rises one cycle after a byte is accepted.
      S_WAIT_LO: state_d = S_SEND_HI;
      S_SEND_HI: begin
        if (!bus.tx_busy) begin
          tx_data_d     = {result_channel_q, 2'b00, result_q[9:8]};
          new_tx_data_d = 1'b1;
          state_d       = S_WAIT_HI;
        end
      end
      S_WAIT_HI: state_d = S_NEXT;
      S_NEXT: begin
        channel_d = next_channel;
        settle_d  = SETTLE_INIT;
        state_d   = S_SETTLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_SETTLE;
      channel_q        <= FIRST_CH;
      settle_q         <= SETTLE_INIT;
      acc_q            <= '0;
      cnt_q            <= '0;
      result_q         <= 10'd0;
      result_channel_q <= 4'd0;
      new_result_q     <= 1'b0;
      tx_data_q        <= 8'd0;
      new_tx_data_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      channel_q        <= channel_d;
      settle_q         <= settle_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      result_q         <= result_d;
      result_channel_q <= result_channel_d;
      new_result_q     <= new_result_d;
      tx_data_q        <= tx_data_d;
      new_tx_data_q    <= new_tx_data_d;
    end
  end

  assign bus.channel        = channel_q;
  assign bus.result         = result_q;
  assign bus.result_channel = result_channel_q;
  assign bus.new_result     = new_result_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.new_tx_data    = new_tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scanner
// Brief    : Self-checking bench for adc_scanner using three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scanner;

  logic clk;
  logic rst;

  // Instance 0: ch0 only, 4-sample average, no settle.
  // Instance 1: default scan mask, 4-sample average, one settle sample.
  // Instance 2: ch10 only, 64-sample average, no settle.
  adc_scanner_if if0 ();
  adc_scanner_if if1 ();
  adc_scanner_if if2 ();

  adc_scanner #(.CHAN_MASK(16'h0001), .AVG_SHIFT(2), .SETTLE(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  adc_scanner #(.CHAN_MASK(16'h03F3), .AVG_SHIFT(2), .SETTLE(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  adc_scanner #(.CHAN_MASK(16'h0400), .AVG_SHIFT(6), .SETTLE(0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  logic       ns   [3];
  logic [9:0] smp  [3];
  logic [3:0] sch  [3];
  logic       busy [3];

  logic [3:0] ch_o  [3];
  logic [9:0] res_o [3];
  logic [3:0] rch_o [3];
  logic       nr_o  [3];
  logic [7:0] txd_o [3];
  logic       ntx_o [3];

  assign if0.new_sample = ns[0];  assign if0.sample = smp[0];
  assign if0.sample_channel = sch[0];  assign if0.tx_busy = busy[0];
  assign if1.new_sample = ns[1];  assign if1.sample = smp[1];
  assign if1.sample_channel = sch[1];  assign if1.tx_busy = busy[1];
  assign if2.new_sample = ns[2];  assign if2.sample = smp[2];
  assign if2.sample_channel = sch[2];  assign if2.tx_busy = busy[2];

  assign ch_o[0] = if0.channel;  assign res_o[0] = if0.result;  assign rch_o[0] = if0.result_channel;
  assign nr_o[0] = if0.new_result;  assign txd_o[0] = if0.tx_data;  assign ntx_o[0] = if0.new_tx_data;
  assign ch_o[1] = if1.channel;  assign res_o[1] = if1.result;  assign rch_o[1] = if1.result_channel;
  assign nr_o[1] = if1.new_result;  assign txd_o[1] = if1.tx_data;  assign ntx_o[1] = if1.new_tx_data;
  assign ch_o[2] = if2.channel;  assign res_o[2] = if2.result;  assign rch_o[2] = if2.result_channel;
  assign nr_o[2] = if2.new_result;  assign txd_o[2] = if2.tx_data;  assign ntx_o[2] = if2.new_tx_data;

  int n_checks;
  int n_fail;

  logic [9:0] exp_res_q  [$];
  logic [3:0] exp_rch_q  [$];
  logic [7:0] exp_byte_q [$];

  bit         got;
  int         cyc;
  logic [9:0] er;
  logic [3:0] ec;
  logic [7:0] eb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_sample(input int k, input logic [3:0] ch, input logic [9:0] v, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    sch[k] = ch;
    smp[k] = v;
    ns[k]  = 1'b1;
    @(posedge clk); #1;
    ns[k]  = 1'b0;
  endtask

  task automatic wait_result(input int k, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nr_o[k]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx(input int k, input int budget, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (ntx_o[k]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_ch [3];
    exp_ch[0] = 4'd0;
    exp_ch[1] = 4'd0;
    exp_ch[2] = 4'd10;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ch_o[k] !== exp_ch[k]) begin
        n_fail++; $display("FAIL reset_channel[%0d]: got %0d, required %0d", k, ch_o[k], exp_ch[k]);
      end
      n_checks++;
      if (res_o[k] !== 10'd0 || rch_o[k] !== 4'd0) begin
        n_fail++; $display("FAIL reset_result[%0d]: got %0d ch %0d, required 0 ch 0", k, res_o[k], rch_o[k]);
      end
      n_checks++;
      if (txd_o[k] !== 8'd0 || nr_o[k] !== 1'b0 || ntx_o[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_strobes[%0d]: got tx_data %h new_result %b new_tx_data %b, required 00 0 0",
                           k, txd_o[k], nr_o[k], ntx_o[k]);
      end
    end
  endtask

  task automatic test_average_frame();
    exp_res_q.push_back(10'd101);
    exp_rch_q.push_back(4'd0);
    exp_byte_q.push_back(8'h65);
    exp_byte_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) send_sample(0, 4'd0, 10'(100 + i), 1);
    wait_result(0, 20, got);
    er = exp_res_q.pop_front();
    ec = exp_rch_q.pop_front();
    n_checks++;
    if (!got || res_o[0] !== er || rch_o[0] !== ec) begin
      n_fail++; $display("FAIL avg_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[0], rch_o[0], got, er, ec);
    end
    wait_tx(0, 20, got, cyc);
    eb = exp_byte_q.pop_front();
    n_checks++;
    if (!got || txd_o[0] !== eb || cyc != 1) begin
      n_fail++; $display("FAIL avg_lo_byte: got %h after %0d cycles (seen=%0d), required %h after 1", txd_o[0], cyc, got, eb);
    end
    wait_tx(0, 20, got, cyc);
    eb = exp_byte_q.pop_front();
    n_checks++;
    if (!got || txd_o[0] !== eb || cyc != 2) begin
      n_fail++; $display("FAIL avg_hi_byte: got %h after %0d cycles (seen=%0d), required %h after 2", txd_o[0], cyc, got, eb);
    end
    repeat (4) @(posedge clk);
    n_checks++;
    if (ch_o[0] !== 4'd0) begin
      n_fail++; $display("FAIL avg_single_mask_channel: got %0d, required 0", ch_o[0]);
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] seq [9];
    logic [9:0] v;
    seq = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ch_o[1] !== seq[i]) begin
        n_fail++; $display("FAIL scan_channel: got %0d, required %0d", ch_o[1], seq[i]);
      end
      v = (seq[i] == 4'd4) ? 10'd40 : 10'(int'(seq[i]) * 100 + 7);
      exp_res_q.push_back(v);
      exp_rch_q.push_back(seq[i]);
      exp_byte_q.push_back(v[7:0]);
      exp_byte_q.push_back({seq[i], 2'b00, v[9:8]});
      // A foreign-channel sample, then one settle sample that must be discarded.
      send_sample(1, seq[i] + 4'd1, 10'd999, 0);
      send_sample(1, seq[i], 10'd0, 0);
      repeat (4) send_sample(1, seq[i], v, 0);
      wait_result(1, 20, got);
      er = exp_res_q.pop_front();
      ec = exp_rch_q.pop_front();
      n_checks++;
      if (!got || res_o[1] !== er || rch_o[1] !== ec) begin
        n_fail++; $display("FAIL scan_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[1], rch_o[1], got, er, ec);
      end
      wait_tx(1, 20, got, cyc);
      eb = exp_byte_q.pop_front();
      n_checks++;
      if (!got || txd_o[1] !== eb) begin
        n_fail++; $display("FAIL scan_lo_byte: got %h (seen=%0d), required %h", txd_o[1], got, eb);
      end
      wait_tx(1, 20, got, cyc);
      eb = exp_byte_q.pop_front();
      n_checks++;
      if (!got || txd_o[1] !== eb || ch_o[1] !== seq[i]) begin
        n_fail++; $display("FAIL scan_hi_byte: got %h on ch %0d (seen=%0d), required %h on ch %0d", txd_o[1], ch_o[1], got, eb, seq[i]);
      end
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (ch_o[1] !== seq[i]) break;
      end
      n_checks++;
      if (ch_o[1] !== seq[i+1]) begin
        n_fail++; $display("FAIL scan_next_channel: got %0d, required %0d", ch_o[1], seq[i+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    busy[0] = 1'b1;
    exp_res_q.push_back(10'd200);
    exp_rch_q.push_back(4'd0);
    exp_byte_q.push_back(8'hC8);
    exp_byte_q.push_back(8'h00);
    repeat (4) send_sample(0, 4'd0, 10'd200, 0);
    wait_result(0, 20, got);
    er = exp_res_q.pop_front();
    ec = exp_rch_q.pop_front();
    n_checks++;
    if (!got || res_o[0] !== er || rch_o[0] !== ec) begin
      n_fail++; $display("FAIL bp_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[0], rch_o[0], got, er, ec);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (ntx_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_lo_while_busy: got new_tx_data %b at cycle %0d, required 0", ntx_o[0], i);
      end
      sch[0] = 4'd0; smp[0] = 10'd1000; ns[0] = (i % 5 == 0);
    end
    ns[0] = 1'b0;
    busy[0] = 1'b0;
    wait_tx(0, 20, got, cyc);
    eb = exp_byte_q.pop_front();
    n_checks++;
    if (!got || txd_o[0] !== eb || cyc != 1) begin
      n_fail++; $display("FAIL bp_lo_byte: got %h after %0d cycles (seen=%0d), required %h after 1", txd_o[0], cyc, got, eb);
    end
    @(posedge clk); #1 busy[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (ntx_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_hi_while_busy: got new_tx_data %b at cycle %0d, required 0", ntx_o[0], i);
      end
      sch[0] = 4'd0; smp[0] = 10'd1000; ns[0] = (i % 5 == 0);
    end
    ns[0] = 1'b0;
    busy[0] = 1'b0;
    wait_tx(0, 20, got, cyc);
    eb = exp_byte_q.pop_front();
    n_checks++;
    if (!got || txd_o[0] !== eb || cyc != 1) begin
      n_fail++; $display("FAIL bp_hi_byte: got %h after %0d cycles (seen=%0d), required %h after 1", txd_o[0], cyc, got, eb);
    end
    // Samples offered during the stall must not leak into this block.
    repeat (4) @(posedge clk);
    exp_res_q.push_back(10'd11);
    exp_rch_q.push_back(4'd0);
    exp_byte_q.push_back(8'h0B);
    exp_byte_q.push_back(8'h00);
    send_sample(0, 4'd0, 10'd10, 0);
    send_sample(0, 4'd0, 10'd10, 0);
    send_sample(0, 4'd0, 10'd10, 0);
    send_sample(0, 4'd0, 10'd14, 0);
    wait_result(0, 20, got);
    er = exp_res_q.pop_front();
    ec = exp_rch_q.pop_front();
    n_checks++;
    if (!got || res_o[0] !== er || rch_o[0] !== ec) begin
      n_fail++; $display("FAIL bp_no_accum_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[0], rch_o[0], got, er, ec);
    end
    for (int b = 0; b < 2; b++) begin
      wait_tx(0, 20, got, cyc);
      eb = exp_byte_q.pop_front();
      n_checks++;
      if (!got || txd_o[0] !== eb) begin
        n_fail++; $display("FAIL bp_no_accum_byte%0d: got %h (seen=%0d), required %h", b, txd_o[0], got, eb);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_full_scale();
    for (int pass = 0; pass < 2; pass++) begin
      er = (pass == 0) ? 10'd1023 : 10'd0;
      exp_res_q.push_back(er);
      exp_rch_q.push_back(4'd10);
      exp_byte_q.push_back(er[7:0]);
      exp_byte_q.push_back({4'd10, 2'b00, er[9:8]});
      for (int i = 0; i < 64; i++) begin
        send_sample(2, 4'd10, (pass == 0) ? 10'd1023 : 10'(i % 2), 0);
      end
      wait_result(2, 20, got);
      er = exp_res_q.pop_front();
      ec = exp_rch_q.pop_front();
      n_checks++;
      if (!got || res_o[2] !== er || rch_o[2] !== ec) begin
        n_fail++; $display("FAIL full_scale_result%0d: got %0d ch %0d (seen=%0d), required %0d ch %0d",
                           pass, res_o[2], rch_o[2], got, er, ec);
      end
      for (int b = 0; b < 2; b++) begin
        wait_tx(2, 20, got, cyc);
        eb = exp_byte_q.pop_front();
        n_checks++;
        if (!got || txd_o[2] !== eb) begin
          n_fail++; $display("FAIL full_scale_byte%0d_%0d: got %h (seen=%0d), required %h", pass, b, txd_o[2], got, eb);
        end
      end
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    int stray;
    exp_res_q.push_back(10'd300);
    exp_rch_q.push_back(4'd0);
    exp_byte_q.push_back(8'h2C);
    exp_byte_q.push_back(8'h01);
    repeat (4) send_sample(0, 4'd0, 10'd300, 0);
    wait_result(0, 20, got);
    er = exp_res_q.pop_front();
    ec = exp_rch_q.pop_front();
    n_checks++;
    if (!got || res_o[0] !== er || rch_o[0] !== ec) begin
      n_fail++; $display("FAIL midrst_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[0], rch_o[0], got, er, ec);
    end
    wait_tx(0, 20, got, cyc);
    eb = exp_byte_q.pop_front();
    n_checks++;
    if (!got || txd_o[0] !== eb) begin
      n_fail++; $display("FAIL midrst_lo_byte: got %h (seen=%0d), required %h", txd_o[0], got, eb);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_byte_q.delete();
    stray = 0;
    @(negedge clk);
    n_checks++;
    if (ch_o[0] !== 4'd0 || res_o[0] !== 10'd0 || rch_o[0] !== 4'd0) begin
      n_fail++; $display("FAIL midrst_state: got ch %0d result %0d result_ch %0d, required 0 0 0", ch_o[0], res_o[0], rch_o[0]);
    end
    for (int i = 0; i < 10; i++) begin
      if (ntx_o[0]) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++; $display("FAIL midrst_no_hi_byte: got %0d tx strobes, required 0", stray);
    end
    exp_res_q.push_back(10'd7);
    exp_rch_q.push_back(4'd0);
    exp_byte_q.push_back(8'h07);
    exp_byte_q.push_back(8'h00);
    repeat (4) send_sample(0, 4'd0, 10'd7, 0);
    wait_result(0, 20, got);
    er = exp_res_q.pop_front();
    ec = exp_rch_q.pop_front();
    n_checks++;
    if (!got || res_o[0] !== er || rch_o[0] !== ec) begin
      n_fail++; $display("FAIL midrst_next_result: got %0d ch %0d (seen=%0d), required %0d ch %0d", res_o[0], rch_o[0], got, er, ec);
    end
    for (int b = 0; b < 2; b++) begin
      wait_tx(0, 20, got, cyc);
      eb = exp_byte_q.pop_front();
      n_checks++;
      if (!got || txd_o[0] !== eb) begin
        n_fail++; $display("FAIL midrst_next_byte%0d: got %h (seen=%0d), required %h", b, txd_o[0], got, eb);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ns[k] = 1'b0; smp[k] = 10'd0; sch[k] = 4'd0; busy[k] = 1'b0;
    end
    test_reset();
    test_average_frame();
    test_scan_order();
    test_backpressure();
    test_full_scale();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/adc_scanner.md
# adc_scanner

Round-robin ADC scan controller downstream of the AVR interface. It drives the interface's requested `channel` and consumes its `new_sample`/`sample`/`sample_channel` stream. It averages 2^AVG_SHIFT samples per enabled channel, then emits the result two ways: as a one-cycle result strobe, and as a two-byte frame on the serial TX user interface. It replaces ad-hoc per-project sampling logic in the top level.

## Interface
- `CHAN_MASK`, 16'h03F3: bit n set = channel n scanned; 16'h0000 treated as 16'h0001.
- `AVG_SHIFT`, 4: log2 of samples averaged per channel; legal 0..6.
- `SETTLE`, 1: matching samples discarded after each channel switch before accumulation; legal 0..15.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `channel` out 4: channel requested from the AVR interface.
- `new_sample` in 1: one-cycle strobe, sample valid.
- `sample` in 10: ADC sample value.
- `sample_channel` in 4: channel the sample belongs to.
- `result` out 10: averaged value, held until next result.
- `result_channel` out 4: channel of `result`.
- `new_result` out 1: one-cycle strobe, `result`/`result_channel` updated this cycle.
- `tx_data` out 8: byte to serial TX.
- `new_tx_data` out 1: one-cycle strobe, `tx_data` valid.
- `tx_busy` in 1: serial TX busy.

## Operation
- States: SETTLE, ACCUM, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, NEXT.
- Reset: state SETTLE. `channel` = lowest set bit of CHAN_MASK. Accumulator, `result`, `result_channel`, `tx_data` = 0. `new_result`, `new_tx_data` = 0. Settle counter = SETTLE.
- **Matching sample:** `new_sample` high and `sample_channel == channel`. Non-matching samples are ignored in every state.
- **SETTLE:** each matching sample decrements the settle counter. When the counter is 0, go to ACCUM; with SETTLE=0 this happens on the next cycle.
- **ACCUM:** each matching sample is added to the accumulator (10+AVG_SHIFT bits, never overflows) and increments the sample count.
  - On the 2^AVG_SHIFT-th sample: `result` <= (acc + sample) >> AVG_SHIFT (truncating); `result_channel` <= `channel`; `new_result` pulses; accumulator and count clear; go to SEND_LO.
- **SEND_LO:** wait for `tx_busy` low. Then drive `tx_data` = result[7:0] and pulse `new_tx_data` for one cycle; go to WAIT_LO.
- **WAIT_LO:** one unconditional cycle, covering the one-cycle `tx_busy` rise latency; go to SEND_HI.
- **SEND_HI:** same handshake as SEND_LO, with byte = {result_channel, 2'b00, result[9:8]}; go to WAIT_HI.
- **WAIT_HI:** one cycle; go to NEXT.
- **NEXT:** `channel` <= next set bit of CHAN_MASK above the current channel, wrapping from 15 to the lowest set bit. A single-bit mask re-selects the same channel. Settle counter reloads SETTLE; go to SETTLE.
- Samples arriving in SEND_*/WAIT_*/NEXT are dropped; no buffering.
- `new_tx_data` is never asserted while `tx_busy` is high, nor on two consecutive cycles.
- A `rst` in any state aborts a frame mid-way (only the low byte may have been sent). All state returns to reset values on the next edge.

## Timing
- All outputs are registered.
- `new_result` is high the cycle after the final matching `new_sample` edge.
- First `new_tx_data` at the earliest that cycle +1, if `tx_busy` is low.
- Minimum frame is 6 cycles from final sample to `channel` change, with `tx_busy` always low: result, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, NEXT.
- `channel` changes exactly once per frame. It is stable from reset or NEXT until the following NEXT.
- A `new_sample` on the same cycle as the FSM leaves ACCUM belongs to the just-finished block (it is the final sample). There is no double count.

## Test plan
- **Averaging and frame:** AVG_SHIFT=2, SETTLE=0, CHAN_MASK=16'h0001, `tx_busy` low; feed ch0 samples 100,101,102,103.
  - `new_result` with `result`=101, `result_channel`=0.
  - Bytes 8'h65 then 8'h00, 2 cycles apart.
- **Scan order with wrap:** CHAN_MASK=16'h03F3.
  - `channel` sequence after reset 0,1,4,5,6,7,8,9,0.
  - Each change follows that channel's frame.
- **Filtering and settle:** SETTLE=1, `channel`=4; feed sample_channel=5 value 999, then ch4 values 0, 40, 40, 40, 40 (AVG_SHIFT=2).
  - The 999 sample is ignored; the first ch4 sample (0) is discarded by settle.
  - `result`=40.
- **TX backpressure:** hold `tx_busy` high for 50 cycles when the frame is ready.
  - No `new_tx_data` while busy; low byte 1 cycle after `tx_busy` falls.
  - Re-raise `tx_busy` for 20 cycles; the high byte waits accordingly.
  - Samples during the wait are not accumulated.
- **Full-scale rounding:** AVG_SHIFT=6, 64 samples of 1023.
  - `result`=1023; high byte {ch,2'b00,2'b11}.
  - Mixed 0/1 alternating samples give `result`=0 (truncation).
- **Reset mid-frame:** assert `rst` the cycle after the low-byte `new_tx_data`.
  - No high byte sent; `channel`=lowest enabled; `result`=0.
  - Next frame starts cleanly from SETTLE.
